// File: rtl/uart_pkg.sv
// UART shared definitions: frame geometry and receiver/transmitter state codes.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;
    localparam int DATA_BITS  = 8;

    localparam logic [2:0] IDLE      = 3'b000;
    localparam logic [2:0] START     = 3'b001;
    localparam logic [2:0] DATA      = 3'b010;
    localparam logic [2:0] STOP      = 3'b011;
    localparam logic [2:0] WAIT_IDLE = 3'b100;

endpackage

// File: rtl/uart_tick_gen.sv
// Oversampling tick prescaler: one-cycle tick every TICK_DIV clocks.
module uart_tick_gen #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == TERM) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // With TICK_DIV=1 the counter sits at 0 and tick is constantly high.
    assign tick = (cnt == TERM);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, 16x oversampled, mid-bit sampling.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = uart_pkg::DATA_BITS,
    parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE,
    parameter int TICK_DIV   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] d_out,
    output logic                 rx_done,
    output logic                 frame_err
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int NW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);

    logic                 sync1;
    logic                 rx_s;
    logic                 tick;
    logic [2:0]           state;
    logic [SW-1:0]        s;
    logic [NW-1:0]        n;
    logic [DATA_BITS-1:0] b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx;
            rx_s  <= sync1;
        end
    end

    uart_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            s         <= '0;
            n         <= '0;
            b         <= '0;
            d_out     <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        s     <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (s == S_MID) begin
                            s <= '0;
                            n <= '0;
                            // A start bit that is gone by mid-bit was a glitch.
                            state <= rx_s ? IDLE : DATA;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (s == S_LAST) begin
                            s <= '0;
                            b <= {rx_s, b[DATA_BITS-1:1]};
                            if (n == N_LAST) begin
                                state <= STOP;
                            end else begin
                                n <= n + 1'b1;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (s == S_LAST) begin
                            s <= '0;
                            if (rx_s) begin
                                d_out   <= b;
                                rx_done <= 1'b1;
                                state   <= IDLE;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= WAIT_IDLE;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames, glitch, framing error, reset.
module tb_uart_rx;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] d_out;
    logic       rx_done;
    logic       frame_err;

    uart_rx #(
        .DATA_BITS (8),
        .OVERSAMPLE(16),
        .TICK_DIV  (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .d_out    (d_out),
        .rx_done  (rx_done),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         err;
        logic [7:0] data;
        int         at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    logic prev_ev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_done || frame_err) begin
                chk("exclusive", 32'(rx_done & frame_err), 0);
                chk("one_cycle", 32'(prev_ev), 0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event done=%0b ferr=%0b d_out=%0h required=none",
                             rx_done, frame_err, d_out);
                end else begin
                    mon_e = sb.pop_front();
                    chk("kind_ferr", 32'(frame_err), 32'(mon_e.err));
                    chk("d_out", 32'(d_out), 32'(mon_e.data));
                    chk("cycle", 32'(cyc), 32'(mon_e.at));
                end
            end
            prev_ev = rx_done | frame_err;
        end
    end

    // Called #1 after a rising edge; the next edge is edge 0 of the frame.
    task automatic send(input logic [7:0] d, input bit stop,
                        input bit err, input logic [7:0] held);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        if (err) sb.push_back('{err: 1'b1, data: held, at: cyc + 155});
        else     sb.push_back('{err: 1'b0, data: d, at: cyc + 155});
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (16) @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int cycles);
        rx = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    int c0;
    int bad;

    initial begin
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_d_out", 32'(d_out), 0);
        chk("rst_rx_done", 32'(rx_done), 0);
        chk("rst_frame_err", 32'(frame_err), 0);
        chk("rst_state", 32'(dut.state), 32'(IDLE));
        rst_n = 1'b1;

        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (dut.state !== IDLE) bad++;
        end
        chk("idle_state_200", 32'(bad), 0);
        chk("idle_d_out", 32'(d_out), 0);

        send(8'h55, 1'b1, 1'b0, 8'h00);
        idle(20);
        chk("t2_state", 32'(dut.state), 32'(IDLE));

        send(8'hA3, 1'b1, 1'b0, 8'h00);
        send(8'h0F, 1'b1, 1'b0, 8'h00);
        idle(20);

        c0 = cyc;
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx = 1'b1;
        while (cyc < c0 + 10) begin
            @(posedge clk);
            #1;
        end
        chk("glitch_start", 32'(dut.state), 32'(START));
        @(posedge clk);
        #1;
        chk("glitch_idle_e10", 32'(dut.state), 32'(IDLE));
        idle(20);
        chk("glitch_d_out", 32'(d_out), 32'h0F);

        send(8'hC4, 1'b0, 1'b1, 8'h0F);
        repeat (40) @(posedge clk);
        #1;
        chk("ferr_wait_idle", 32'(dut.state), 32'(WAIT_IDLE));
        chk("ferr_d_out_held", 32'(d_out), 32'h0F);
        idle(20);
        chk("ferr_back_idle", 32'(dut.state), 32'(IDLE));
        send(8'h12, 1'b1, 1'b0, 8'h00);
        idle(20);

        rx = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (72) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_d_out", 32'(d_out), 0);
        chk("async_rx_done", 32'(rx_done), 0);
        chk("async_frame_err", 32'(frame_err), 0);
        chk("async_state", 32'(dut.state), 32'(IDLE));
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(10);
        chk("post_rst_state", 32'(dut.state), 32'(IDLE));
        send(8'h81, 1'b1, 1'b0, 8'h00);
        idle(20);

        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        chk("sb_empty", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
